// File: rtl/bcd_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared BCD constants and controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_add_ctrl_if
// Brief    : Request/result bundle between a requester and the BCD controller.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_serial_add_ctrl_if
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
);
    localparam int W = DIGIT_W * NDIGITS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );

endinterface
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_add
// Brief    : Combinational one-digit decimal-correcting adder.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import bcd_pkg::*;
(
    input  wire logic [DIGIT_W-1:0] a_d,
    input  wire logic [DIGIT_W-1:0] b_d,
    input  wire logic               ci,
    output logic      [DIGIT_W-1:0] s_d,
    output logic                    co
);

    logic [DIGIT_W:0] w_z;
    logic [DIGIT_W:0] w_zc;

    // Non-BCD digits still go through the same correction; only the low
    // nibble of the corrected value is kept.
    always_comb begin
        w_z  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, ci};
        w_zc = w_z + (DIGIT_W+1)'(BCD_CORR);
        if (w_z > (DIGIT_W+1)'(BCD_MAX)) begin
            s_d = w_zc[DIGIT_W-1:0];
            co  = 1'b1;
        end else begin
            s_d = w_z[DIGIT_W-1:0];
            co  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Brief    : Digit-serial packed-BCD adder controller, LSD first, one digit/clk.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
)(
    input  wire logic            clk,
    input  wire logic            rst,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int W     = DIGIT_W * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NDIGITS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic               r_busy;
    logic               r_done;

    logic [DIGIT_W-1:0] w_a_d;
    logic [DIGIT_W-1:0] w_b_d;
    logic [DIGIT_W-1:0] w_s_d;
    logic               w_co;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_idx == c_last_idx);
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN:     if (w_last) w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_a_d = '0;
        w_b_d = '0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_d = r_a[k*DIGIT_W +: DIGIT_W];
                w_b_d = r_b[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

    bcd_digit_add u_digit_add (
        .a_d (w_a_d),
        .b_d (w_b_d),
        .ci  (r_carry),
        .s_d (w_s_d),
        .co  (w_co)
    );

    // busy/done are flopped from the next state so every output is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == RUN);
            r_done <= (w_state_next == DONE);
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_err   <= 1'b0;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                for (int k = 0; k < NDIGITS; k++) begin
                    if (r_idx == IDX_W'(k)) r_sum[k*DIGIT_W +: DIGIT_W] <= w_s_d;
                end
                r_carry <= w_co;
                r_err   <= r_err | (w_a_d > DIGIT_W'(BCD_MAX)) | (w_b_d > DIGIT_W'(BCD_MAX));
                if (w_last) r_cout <= w_co;
                else        r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_add_ctrl
// Brief    : Self-checking bench: vector table, corner sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;
    import bcd_pkg::*;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.NDIGITS(N)) bus ();

    bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Decimal value of an all-valid BCD word, and back.
    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int k = N - 1; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < N; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                  output logic [W-1:0] s, output logic co, output logic e);
        longint lim = 1;
        longint tot;
        int     c;
        e = 1'b0;
        for (int k = 0; k < N; k++) begin
            lim = lim * 10;
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e = 1'b1;
        end
        if (!e) begin
            tot = bcd2int(a) + bcd2int(b) + longint'(cin);
            co  = (tot >= lim);
            s   = int2bcd(tot % lim);
        end else begin
            c = int'(cin);
            s = '0;
            for (int k = 0; k < N; k++) begin
                int z = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + c;
                if (z > 9) begin s[4*k +: 4] = 4'((z + 6) % 16); c = 1; end
                else       begin s[4*k +: 4] = 4'(z);            c = 0; end
            end
            co = c[0];
        end
    endfunction

    // Issue one op from the current cycle; returns in the done cycle
    // (or one cycle later when settle is set).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input logic ee,
                          input string name, input bit hold_start, input bit settle);
        int n;
        int bcnt;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        tick;
        if (!hold_start) bus.start = 1'b0;
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom);
        n    = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && n < 4 * N) begin
            if (bus.busy === 1'b1) bcnt++;
            tick;
            n++;
        end
        check({name, ".latency"}, 32'(n), 32'(N));
        check({name, ".busy_cycles"}, 32'(bcnt), 32'(N));
        check({name, ".busy_at_done"}, 32'(bus.busy), 32'(0));
        check({name, ".sum"}, 32'(bus.sum), 32'(es));
        check({name, ".cout"}, 32'(bus.cout), 32'(ec));
        check({name, ".err"}, 32'(bus.err), 32'(ee));
        if (settle) begin
            bus.start = 1'b0;
            tick;
            check({name, ".done_pulse"}, 32'(bus.done), 32'(0));
            check({name, ".idle_busy"}, 32'(bus.busy), 32'(0));
            check({name, ".sum_hold"}, 32'(bus.sum), 32'(es));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, ec, ee;
        int           dcnt;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        // A+0 is corrected to 0 with a carry that ripples into digit 2.
        vecs[3] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h4821, 16'h3179, 1'b1, 16'h8001, 1'b0, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        tick;
        tick;
        check("reset.busy", 32'(bus.busy), 32'(0));
        check("reset.done", 32'(bus.done), 32'(0));
        check("reset.sum",  32'(bus.sum),  32'(0));
        check("reset.cout", 32'(bus.cout), 32'(0));
        check("reset.err",  32'(bus.err),  32'(0));
        rst = 1'b0;
        tick;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].err,
                   $sformatf("vec%0d", i), 1'b0, 1'b1);

        // start held through RUN, still high in DONE with new operands.
        run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, "hold", 1'b1, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, "b2b", 1'b0, 1'b1);

        // Abort in the third RUN cycle after digits 0 and 1 (with a bad digit) are written.
        bus.start = 1'b1;
        bus.a = 16'h123F;
        bus.b = 16'h5678;
        bus.cin = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort.busy", 32'(bus.busy), 32'(0));
        check("abort.done", 32'(bus.done), 32'(0));
        check("abort.sum",  32'(bus.sum),  32'(0));
        check("abort.cout", 32'(bus.cout), 32'(0));
        check("abort.err",  32'(bus.err),  32'(0));
        dcnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
            tick;
        end
        check("abort.no_done", 32'(dcnt), 32'(0));

        // rst wins over start on the same edge.
        rst = 1'b1;
        bus.start = 1'b1;
        tick;
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_prio.busy", 32'(bus.busy), 32'(0));
        tick;
        check("rst_prio.busy2", 32'(bus.busy), 32'(0));

        run_op(16'h0457, 16'h0368, 1'b0, 16'h0825, 1'b0, 1'b0, "post_abort", 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                ra[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                rb[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom);
            model(ra, rb, rc, es, ec, ee);
            run_op(ra, rb, rc, es, ec, ee, $sformatf("rnd%0d", i), 1'b0, 1'($urandom));
        end

        bus.start = 1'b0;
        tick;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
